// File: rtl/rvga_types.sv
// Shared types for the rvga DDR arbiter: FSM state and requester identifiers.
package rvga_types;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_REQ_I = 1'b0,
        ARB_REQ_D = 1'b1
    } arb_req_t;

    function automatic arb_req_t arb_other(input arb_req_t req);
        return (req == ARB_REQ_I) ? ARB_REQ_D : ARB_REQ_I;
    endfunction

endpackage

// File: rtl/rvga_arb_select.sv
// Combinational winner selection between the icache and dcache requests.
module rvga_arb_select
    import rvga_types::*;
(
    input  logic     icache_req_i,
    input  logic     dcache_req_i,
    input  arb_req_t rr_ptr_i,
    output arb_req_t winner_o
);

    // Ties go to whichever requester the pointer prefers.
    always_comb begin
        winner_o = ARB_REQ_D;
        if (icache_req_i && dcache_req_i) begin
            winner_o = rr_ptr_i;
        end else if (icache_req_i) begin
            winner_o = ARB_REQ_I;
        end else begin
            winner_o = ARB_REQ_D;
        end
    end

endmodule

// File: rtl/rvga_ddr_arbiter_chk.sv
// Simulation-only checker: the dcache must never request read and write together.
module rvga_ddr_arbiter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic dcache_read_i,
    input logic dcache_write_i
);

    // Flag an illegal simultaneous read/write from the dcache.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(dcache_read_i && dcache_write_i))
                else $error("rvga_ddr_arbiter: dcache read and write both asserted");
        end
    end

endmodule

// File: rtl/rvga_ddr_arbiter.sv
// Shares one DDR port between icache and dcache; define RVGA_ARB_RR_EN for
// round-robin tie breaking, otherwise the dcache always wins ties.
module rvga_ddr_arbiter
    import rvga_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] icache_arb_addr,
    input  logic              icache_arb_read,
    output logic [DATA_W-1:0] arb_icache_rdata,
    output logic              arb_icache_resp,
    input  logic [ADDR_W-1:0] dcache_arb_addr,
    input  logic              dcache_arb_read,
    input  logic              dcache_arb_write,
    input  logic [DATA_W-1:0] dcache_arb_wdata,
    output logic [DATA_W-1:0] arb_dcache_rdata,
    output logic              arb_dcache_resp,
    output logic [ADDR_W-1:0] arb_ddr_addr,
    output logic              arb_ddr_read,
    output logic              arb_ddr_write,
    output logic [DATA_W-1:0] arb_ddr_wdata,
    input  logic [DATA_W-1:0] ddr_arb_rdata,
    input  logic              ddr_arb_resp
);

    arb_state_t state_q, state_d;
    arb_req_t   rr_ptr_s, winner_s;
    logic       icache_req_s, dcache_req_s;

    assign icache_req_s = icache_arb_read;
    assign dcache_req_s = dcache_arb_read | dcache_arb_write;

`ifdef RVGA_ARB_RR_EN
    arb_req_t rr_ptr_q, rr_ptr_d;

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q <= ARB_REQ_D;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // After every grant, prefer the requester that was not granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((state_q == ARB_IDLE) && (icache_req_s || dcache_req_s)) begin
            rr_ptr_d = arb_other(winner_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    assign rr_ptr_s = rr_ptr_q;
`else
    assign rr_ptr_s = ARB_REQ_D;
`endif

    rvga_arb_select u_select (
        .icache_req_i (icache_req_s),
        .dcache_req_i (dcache_req_s),
        .rr_ptr_i     (rr_ptr_s),
        .winner_o     (winner_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant from IDLE, return to IDLE on DDR completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (icache_req_s || dcache_req_s) begin
                    state_d = (winner_s == ARB_REQ_I) ? ARB_SERVE_I : ARB_SERVE_D;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (ddr_arb_resp) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // DDR port muxing and response routing; lines are forwarded live, never latched.
    always_comb begin
        arb_ddr_addr     = '0;
        arb_ddr_read     = 1'b0;
        arb_ddr_write    = 1'b0;
        arb_ddr_wdata    = '0;
        arb_icache_resp  = 1'b0;
        arb_icache_rdata = '0;
        arb_dcache_resp  = 1'b0;
        arb_dcache_rdata = '0;
        case (state_q)
            ARB_SERVE_I: begin
                arb_ddr_addr = icache_arb_addr;
                arb_ddr_read = icache_arb_read;
                if (ddr_arb_resp) begin
                    arb_icache_resp  = 1'b1;
                    arb_icache_rdata = ddr_arb_rdata;
                end else begin
                    arb_icache_resp  = 1'b0;
                    arb_icache_rdata = '0;
                end
            end
            ARB_SERVE_D: begin
                arb_ddr_addr  = dcache_arb_addr;
                arb_ddr_read  = dcache_arb_read & ~dcache_arb_write;
                arb_ddr_write = dcache_arb_write;
                arb_ddr_wdata = dcache_arb_wdata;
                if (ddr_arb_resp) begin
                    arb_dcache_resp  = 1'b1;
                    arb_dcache_rdata = ddr_arb_rdata;
                end else begin
                    arb_dcache_resp  = 1'b0;
                    arb_dcache_rdata = '0;
                end
            end
            default: begin
                arb_ddr_addr = '0;
            end
        endcase
    end

    rvga_ddr_arbiter_chk u_chk (
        .clk_i          (clk),
        .rst_ni         (rst),
        .dcache_read_i  (dcache_arb_read),
        .dcache_write_i (dcache_arb_write)
    );

endmodule

// File: doc/rvga_ddr_arbiter.md
# rvga_ddr_arbiter

Shares one DDR port between the instruction cache and the data cache of `rvga_top`, so the system needs only one memory model or controller. Each cache holds a request (read or write, with address and data) until it receives a one-cycle `resp`. The arbiter grants one requester at a time, forwards its request to the DDR, and routes the DDR response back to that requester. It sits between the cache miss interfaces and the single `test_ddr` or real DDR controller.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset; `rst==0` at a rising edge resets the block
- `icache_arb_addr`  in  ADDR_W  icache request address
- `icache_arb_read`  in  1  icache read request, held until `arb_icache_resp`
- `arb_icache_rdata`  out  DATA_W  read data returned to the icache
- `arb_icache_resp`  out  1  one-cycle completion pulse to the icache
- `dcache_arb_addr`  in  ADDR_W  dcache request address
- `dcache_arb_read`  in  1  dcache read request, held until resp
- `dcache_arb_write`  in  1  dcache write request, held until resp
- `dcache_arb_wdata`  in  DATA_W  dcache write data
- `arb_dcache_rdata`  out  DATA_W  read data returned to the dcache
- `arb_dcache_resp`  out  1  one-cycle completion pulse to the dcache
- `arb_ddr_addr`  out  ADDR_W  DDR address
- `arb_ddr_read`  out  1  DDR read request
- `arb_ddr_write`  out  1  DDR write request
- `arb_ddr_wdata`  out  DATA_W  DDR write data
- `ddr_arb_rdata`  in  DATA_W  DDR read data
- `ddr_arb_resp`  in  1  DDR completion pulse

## Operation
State machine with three states: IDLE, SERVE_I, SERVE_D.

IDLE:
- DDR read/write deasserted.
- Requests are evaluated each cycle. icache request = `icache_arb_read`; dcache request = `dcache_arb_read | dcache_arb_write`.
- Only icache requesting: next state SERVE_I.
- Only dcache requesting: next state SERVE_D.
- Both requesting: priority rule (see Configuration) picks the next state.
- No request: stay in IDLE.

SERVE_I:
- DDR port driven from the icache: addr, read; write=0; wdata=0.
- On `ddr_arb_resp`:
  - `arb_icache_resp`=1 in the same cycle.
  - `arb_icache_rdata` is `ddr_arb_rdata` passed through combinationally.
  - Next state IDLE.

SERVE_D:
- DDR port driven from the dcache: addr, read, write, wdata.
- On `ddr_arb_resp`: `arb_dcache_resp`=1 and rdata passed through; next state IDLE.

Other rules:
- A requester never sees resp while it is not granted.
- `ddr_arb_resp` in IDLE is ignored: no resp to either requester.
- rdata outputs are 0 whenever their resp is 0.
- `dcache_arb_read` and `dcache_arb_write` both high is illegal. Simulation assertion fires; write is forwarded and read is dropped.
- A requester's lines may change only after its resp. Changes during SERVE are forwarded as-is and are not latched.

## Timing
- Reset values: state=IDLE; RR pointer=dcache.
- Reset values of outputs: all resp, read and write outputs =0; addr, wdata and rdata outputs =0.
- Grant latency: request first seen at cycle n in IDLE → DDR read/write asserted at cycle n+1.
- Response latency: DDR resp at cycle k → requester resp at cycle k (zero added latency).
- Back-to-back: after a resp at cycle k the arbiter is in IDLE at k+1. A pending request is granted at k+1 and reaches the DDR at k+2, a one-cycle bubble.
- Reset mid-transaction: IDLE on the next edge; DDR read/write drop; no resp is issued to either requester. The DDR side must tolerate an abandoned transaction.

## Configuration
- `RVGA_ARB_RR_EN` defined: round-robin arbitration.
  - A one-bit pointer names the preferred requester when both request.
  - The pointer flips to the other requester whenever a grant is made.
- `RVGA_ARB_RR_EN` undefined: fixed priority, dcache always wins ties; pointer logic is absent.

## Structure
- In package `rvga_types`:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_SERVE_I`, `ARB_SERVE_D`)
  - `arb_req_t` enum (`ARB_REQ_I`, `ARB_REQ_D`)
- One sub-module `rvga_arb_select`: combinational winner selection from the two request bits and the RR pointer, outputting `arb_req_t`. The FSM, pointer register and DDR muxes stay in `rvga_ddr_arbiter`.

## Test plan
- icache read of 0x100 alone, DDR returning 0xDEADBEEF after 3 cycles → `arb_ddr_read` one cycle after the request; `arb_icache_resp` for one cycle with rdata 0xDEADBEEF; dcache resp stays 0.
- dcache write of 0x55AA00FF to 0x200 → `arb_ddr_write`=1, addr 0x200, wdata 0x55AA00FF; `arb_dcache_resp` on the DDR resp cycle; `arb_ddr_read`=0 throughout.
- Both requesting at once, fixed priority → dcache served first, icache served next, one-cycle IDLE bubble between them.
- With `RVGA_ARB_RR_EN`, both requesting continuously for 4 transactions → grants alternate D, I, D, I.
- `rst`=0 while SERVE_D is waiting on the DDR → read/write low next cycle, no resp issued; after `rst`=1 a new icache request is granted normally.
- `ddr_arb_resp` pulsed in IDLE → both requester resps stay 0 and the state stays IDLE.
